// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter and select controller for a shared 4:1 datapath mux.
//   Four sources request the mux. Exactly one owner is granted at a time.
//   The owner keeps the mux until it strobes done, drops its request, or
//   holds it for MAX_HOLD cycles while another source is waiting. In that
//   last case the grant is preempted and rotates to the next requester.
//
// Ports
//   clk       in   1      system clock, rising edge
//   reset_n   in   1      asynchronous active-low reset
//   req       in   4      level request per source, held until granted
//   done      in   1      release strobe from the current owner (ignored when idle)
//   sel       out  2      mux select; index of the current or most recent owner
//   gnt       out  4      one-hot grant, all zero when idle
//   busy      out  1      a grant is active
//   preempt   out  1      one-cycle pulse after a grant is ended only by timeout
//   hold_cnt  out  CNT_W  cycles elapsed in the current grant
//
// State table
//   state   | meaning
//   S_IDLE  | no owner; the next nonzero req is granted on the following edge
//   S_GRANT | sel owns the mux; hold_cnt counts the cycles it has held it
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       req,
  input  logic             done,
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             preempt,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  // Last cycle a contended grant may run before it is forced to rotate.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  // Uncontended grants stop counting here. With the timeout disabled the
  // counter runs up to all-ones.
  localparam logic [CNT_W-1:0] HOLD_SAT  = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : HOLD_LAST;

  logic [0:0]       state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [1:0]       sel_n;
  logic [3:0]       gnt_n;
  logic             busy_n;
  logic             preempt_n;
  logic [CNT_W-1:0] hold_n;

  logic [3:0] owner_mask;
  logic       contender;
  logic       rel_done, rel_drop, rel_tmo, release_now;
  logic [1:0] pick_base;
  logic       pick_found;
  logic [1:0] pick_idx;

  // Pick the first set request bit, scanning upward from base and wrapping at 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = base + 2'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    owner_mask  = 4'b0001 << sel;
    contender   = |(req & ~owner_mask);
    rel_done    = done;
    rel_drop    = ~req[sel];
    rel_tmo     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && contender;
    release_now = rel_done | rel_drop | rel_tmo;

    // On release the search starts just past the owner, so the owner
    // comes last in priority.
    pick_base = (state == S_GRANT) ? (sel + 2'd1) : ptr;
    {pick_found, pick_idx} = rr_pick(req, pick_base);
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    sel_n     = sel;
    gnt_n     = gnt;
    busy_n    = busy;
    preempt_n = 1'b0;
    hold_n    = hold_cnt;

    case (state)
      S_IDLE: begin
        if (pick_found) begin
          state_n = S_GRANT;
          sel_n   = pick_idx;
          gnt_n   = 4'b0001 << pick_idx;
          busy_n  = 1'b1;
          hold_n  = '0;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          ptr_n     = sel + 2'd1;
          preempt_n = rel_tmo & ~rel_done & ~rel_drop;
          if (pick_found) begin
            // Hand over directly, or re-grant the sole requester, with no idle bubble.
            sel_n  = pick_idx;
            gnt_n  = 4'b0001 << pick_idx;
            hold_n = '0;
          end else begin
            state_n = S_IDLE;
            gnt_n   = 4'b0000;
            busy_n  = 1'b0;
            hold_n  = '0;
          end
        end else if (hold_cnt != HOLD_SAT) begin
          hold_n = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = 4'b0000;
        busy_n  = 1'b0;
        hold_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      gnt      <= 4'b0000;
      busy     <= 1'b0;
      preempt  <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      sel      <= sel_n;
      gnt      <= gnt_n;
      busy     <= busy_n;
      preempt  <= preempt_n;
      hold_cnt <= hold_n;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int MAXH = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    req = 4'b0000;
  logic          done = 1'b0;
  logic [1:0]    sel;
  logic [3:0]    gnt;
  logic          busy;
  logic          preempt;
  logic [CW-1:0] hold_cnt;

  mux4_rr_arbiter #(.MAX_HOLD(MAXH), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .done(done),
    .sel(sel), .gnt(gnt), .busy(busy), .preempt(preempt), .hold_cnt(hold_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: owner index, rotation pointer, and a plain integer hold count.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_pre;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;
    int         hold;   // -1: not checked
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_search(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_pre = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int w;
    bit a, b, c;
    int cap;
    cap = (MAXH == 0) ? (1 << CW) - 1 : MAXH - 1;
    if (!m_busy) begin
      m_pre = 0;
      w = rr_search(m_ptr, r);
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_hold = 0;
      end
    end else begin
      a = d;
      b = !r[m_owner];
      c = (MAXH != 0) && (m_hold == MAXH - 1) && ((r & ~(4'b0001 << m_owner)) != 4'b0000);
      if (a || b || c) begin
        m_ptr = (m_owner + 1) % 4;
        m_pre = c && !a && !b;
        w = rr_search(m_ptr, r);
        if (w >= 0) begin
          m_owner = w; m_hold = 0;
        end else begin
          m_busy = 0;
        end
      end else begin
        m_pre = 0;
        if (m_hold < cap) m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".gnt"}, gnt, m_busy ? (4'b0001 << m_owner) : 4'b0000);
    chk({tag, ".sel"}, sel, m_owner[1:0]);
    chk({tag, ".busy"}, busy, m_busy);
    chk({tag, ".preempt"}, preempt, m_pre);
    if (m_busy) chk({tag, ".hold"}, hold_cnt, m_hold);
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    req = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = 4'b0000;
    done = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int last_sel;
    bit gap;
    bit pre_seen;
    bit gnt_bad;
    logic [3:0] rreq;
    logic       rdone;

    //           req      done  gnt      sel  busy pre  hold
    tbl[0]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 0};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1};
    tbl[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, -1};
    tbl[3]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0, 0};
    tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, -1};
    tbl[5]  = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0, 0};
    tbl[6]  = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 0};
    tbl[7]  = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 0};
    for (int i = 1; i <= 7; i++)
      tbl[7 + i] = '{4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, i};
    tbl[15] = '{4'b0110, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 0};
    tbl[16] = '{4'b0110, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1};

    // Reset state
    do_reset();
    chk("rst.gnt", gnt, 4'b0000);
    chk("rst.sel", sel, 2'd0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.preempt", preempt, 1'b0);
    chk("rst.hold", hold_cnt, 0);

    // Vector table
    foreach (tbl[i]) begin
      step(tbl[i].req, tbl[i].done);
      chk($sformatf("tbl%0d.gnt", i), gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d.sel", i), sel, tbl[i].sel);
      chk($sformatf("tbl%0d.busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d.preempt", i), preempt, tbl[i].preempt);
      if (tbl[i].hold >= 0) chk($sformatf("tbl%0d.hold", i), hold_cnt, tbl[i].hold);
      compare_model($sformatf("tbl%0d.model", i));
    end

    // Asynchronous reset in the middle of a grant, away from any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst.gnt", gnt, 4'b0000);
    chk("async_rst.sel", sel, 2'd0);
    chk("async_rst.busy", busy, 1'b0);
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;

    // All four requesting, done every third cycle: rotation 0,1,2,3,0 with no gap
    step(4'b1111, 1'b0);
    order.push_back(int'(sel));
    last_sel = int'(sel);
    gap = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'b1111, (i % 3) == 2);
      compare_model("rr");
      if (!busy) gap = 1;
      if (int'(sel) != last_sel) begin
        order.push_back(int'(sel));
        last_sel = int'(sel);
      end
    end
    chk("rr.no_gap", gap, 1'b0);
    chk("rr.count", order.size(), 5);
    if (order.size() == 5) begin
      chk("rr.o0", order[0], 0);
      chk("rr.o1", order[1], 1);
      chk("rr.o2", order[2], 2);
      chk("rr.o3", order[3], 3);
      chk("rr.o4", order[4], 0);
    end

    // Timeout rotation with two contenders
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b0011, 1'b0);
      chk($sformatf("tmo.hold%0d", i), hold_cnt, i);
      chk($sformatf("tmo.gnt%0d", i), gnt, 4'b0001);
      compare_model("tmo");
    end
    step(4'b0011, 1'b0);
    chk("tmo.rot_gnt", gnt, 4'b0010);
    chk("tmo.rot_sel", sel, 2'd1);
    chk("tmo.rot_preempt", preempt, 1'b1);
    chk("tmo.rot_hold", hold_cnt, 0);
    step(4'b0011, 1'b0);
    chk("tmo.preempt_pulse", preempt, 1'b0);
    compare_model("tmo_end");

    // Sole requester: no timeout, counter saturates
    do_reset();
    pre_seen = 0;
    gnt_bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, 1'b0);
      if (preempt) pre_seen = 1;
      if (gnt !== 4'b0001) gnt_bad = 1;
      compare_model("sat");
    end
    chk("sat.hold", hold_cnt, MAXH - 1);
    chk("sat.preempt_seen", pre_seen, 1'b0);
    chk("sat.gnt_stable", gnt_bad, 1'b0);

    // Randomized traffic against the model
    do_reset();
    rreq = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rreq = 4'($urandom);
      rdone = ($urandom_range(0, 6) == 0);
      step(rreq, rdone);
      compare_model("rand");
      chk("rand.onehot", $countones(gnt) <= 1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and select controller for a shared 4-input, n-bit datapath mux. It accepts requests from four sources and grants the mux to exactly one of them at a time. It drives the 2-bit mux select and a one-hot grant. Ownership is held until the owner releases it or a hold-limit timeout forces rotation. It sits between the four requesting units and the select input of the shared 4:1 mux.

Parameters:
MAX_HOLD, 8, maximum consecutive GRANT cycles before forced release when another source is requesting; 0 disables timeout.
CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req  input  4  request from source i; level, held while the source wants the mux
done  input  1  release strobe from the current owner; ignored in IDLE
sel  output  2  mux select = index of the current or last owner
gnt  output  4  one-hot grant; all zero when idle
busy  output  1  high while any grant is active
preempt  output  1  one-cycle pulse when a grant is ended by timeout
hold_cnt  output  CNT_W  cycles elapsed in the current grant

Behaviour:
- All outputs and internal state are registered; single clock domain.
- Reset (async, reset_n=0):
  - state=IDLE; sel=0; gnt=0; busy=0; preempt=0; hold_cnt=0; rotation pointer ptr=0.
  - Takes effect immediately, including mid-grant.
  - First grant is possible on the first rising edge after reset_n rises.
- State IDLE:
  - gnt=0, busy=0.
  - If req!=0, search indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and pick the first set bit w.
  - Next edge: state=GRANT, gnt=1<<w, sel=w, busy=1, hold_cnt=0.
  - Latency: req sampled at edge k, gnt visible after edge k (1 cycle).
- State GRANT, owner o. Release condition, evaluated each edge, is any of:
  - (a) done=1
  - (b) req[o]=0
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and (req & ~(1<<o))!=0 (timeout)
- On release:
  - ptr = (o+1) mod 4.
  - Search req from the new ptr; o is naturally last in priority.
  - If a winner w exists and is not o under condition (b): go directly to GRANT(w) on the same edge. No idle bubble: gnt switches one-hot to one-hot, sel=w, hold_cnt=0, busy stays 1.
  - If the only requester is o and (b) did not apply, re-grant o with hold_cnt=0.
  - If no requester: state=IDLE, gnt=0, busy=0, sel holds its last value.
- preempt=1 for exactly the cycle following a release caused solely by (c). If (a) or (b) also holds on that edge, preempt=0.
- No release:
  - hold_cnt increments.
  - It saturates at MAX_HOLD-1 when no contender exists; with MAX_HOLD=0 it saturates at all-ones.
  - gnt and sel stay stable.
- Requests from non-owners during GRANT are not latched. Sources must hold req until granted.
- gnt always has at most one bit set; gnt[sel]==1 whenever busy=1.
- Simultaneous done and timeout count as a normal release (preempt=0).

Test Plan:
- Reset then req=4'b0100 → after 1 edge: gnt=0100, sel=2, busy=1, hold_cnt=0. Assert reset_n=0 mid-grant → gnt=0, sel=0, busy=0 with no clock edge.
- From reset, req=4'b1111, done pulsed every 3rd cycle → grant order 0,1,2,3,0; sel switches directly, busy never drops, no idle gap.
- MAX_HOLD=8, req=4'b0011 held, no done → owner 0 for 8 cycles (hold_cnt 0..7), then gnt=0010, sel=1, preempt=1 for one cycle.
- MAX_HOLD=8, req=4'b0001 only, held 20 cycles → gnt=0001 throughout, hold_cnt saturates at 7, preempt never asserted.
- Owner 3 drops req while req=4'b0000 elsewhere → next edge: IDLE, gnt=0, busy=0, sel stays 3. Then req=4'b1001 → gnt=0001 (ptr=0).
- done and timeout on the same edge with req=4'b0110, owner 1 → gnt=0100, sel=2, preempt=0.
